// File: rtl/sdio_init_ctrl.sv
// SD card bring-up sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7.
// Drives one command transmitter and one response receiver, then reports RCA and CCS.
module sdio_init_ctrl #(
    parameter int unsigned PWRUP_CYC    = 80,
    parameter int unsigned GAP_CYC      = 16,
    parameter int unsigned RSP_TIMEOUT  = 4096,
    parameter int unsigned ACMD41_RETRY = 1000
) (
    input  logic        ctrl_clk,
    input  logic        rst,
    input  logic        i_start,
    output logic        o_tx_en,
    output logic [5:0]  o_tx_cmd,
    output logic [31:0] o_tx_para,
    input  logic        i_tx_done,
    output logic        o_rx_listen,
    output logic        o_rx_rsp136en,
    input  logic        i_rx_done,
    input  logic        i_rx_crcerr,
    input  logic [31:0] i_rx_arg,
    output logic        clk_mod,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_init_err,
    output logic [3:0]  o_err_code,
    output logic [15:0] o_rca,
    output logic        o_ccs
);
    localparam int unsigned CNT_MAX = (RSP_TIMEOUT > PWRUP_CYC) ?
        ((RSP_TIMEOUT > GAP_CYC) ? RSP_TIMEOUT : GAP_CYC) :
        ((PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC);
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned RTY_W = $clog2(ACMD41_RETRY + 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(RSP_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST   = RTY_W'(ACMD41_RETRY - 1);

    typedef enum logic [2:0] {
        StIdle, StPwrup, StSend, StWaitTx, StWaitRsp, StGap, StDone, StErr
    } state_e;

    typedef enum logic [2:0] {
        StepCmd0, StepCmd8, StepCmd55, StepAcmd41, StepCmd2, StepCmd3, StepCmd7
    } step_e;

    state_e           state_q;
    step_e            step_q;
    step_e            rsp_next;
    logic [CNT_W-1:0] cnt_q;
    logic [RTY_W-1:0] retry_q;
    logic [5:0]       cur_cmd;
    logic [31:0]      cur_para;
    logic [3:0]       cur_code;
    logic             rsp_fail;
    logic             unused_arg;

    assign unused_arg = ^i_rx_arg[15:12];

    // Command encoding for the current step, and evaluation of a response to it.
    always_comb begin
        cur_cmd  = 6'd0;
        cur_para = 32'h0;
        cur_code = 4'd0;
        rsp_fail = i_rx_crcerr && (step_q != StepAcmd41);
        rsp_next = step_q;
        unique case (step_q)
            StepCmd0: cur_cmd = 6'd0;
            StepCmd8: begin
                cur_cmd  = 6'd8;
                cur_para = 32'h0000_01AA;
                cur_code = 4'd1;
                rsp_next = StepCmd55;
                if (i_rx_arg[11:0] != 12'h1AA) rsp_fail = 1'b1;
            end
            StepCmd55: begin
                cur_cmd  = 6'd55;
                cur_para = {o_rca, 16'h0};
                cur_code = 4'd6;
                rsp_next = StepAcmd41;
            end
            StepAcmd41: begin
                cur_cmd  = 6'd41;
                cur_para = 32'h40FF_8000;
                cur_code = 4'd2;
                if (i_rx_arg[31]) rsp_next = StepCmd2;
                else if (retry_q == RTY_LAST) rsp_fail = 1'b1;
                else rsp_next = StepCmd55;
            end
            StepCmd2: begin
                cur_cmd  = 6'd2;
                cur_code = 4'd3;
                rsp_next = StepCmd3;
            end
            StepCmd3: begin
                cur_cmd  = 6'd3;
                cur_code = 4'd4;
                rsp_next = StepCmd7;
                if (i_rx_arg[31:16] == 16'h0) rsp_fail = 1'b1;
            end
            StepCmd7: begin
                cur_cmd  = 6'd7;
                cur_para = {o_rca, 16'h0};
                cur_code = 4'd5;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ctrl_clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            step_q        <= StepCmd0;
            cnt_q         <= '0;
            retry_q       <= '0;
            o_tx_en       <= 1'b0;
            o_tx_cmd      <= 6'd0;
            o_tx_para     <= 32'h0;
            o_rx_listen   <= 1'b0;
            o_rx_rsp136en <= 1'b0;
            clk_mod       <= 1'b1;
            o_busy        <= 1'b0;
            o_init_done   <= 1'b0;
            o_init_err    <= 1'b0;
            o_err_code    <= 4'd0;
            o_rca         <= 16'h0;
            o_ccs         <= 1'b0;
        end else begin
            o_tx_en <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (i_start) begin
                        o_init_done <= 1'b0;
                        o_init_err  <= 1'b0;
                        o_err_code  <= 4'd0;
                        o_rca       <= 16'h0;
                        o_ccs       <= 1'b0;
                        retry_q     <= '0;
                        clk_mod     <= 1'b1;
                        o_busy      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StPwrup;
                    end
                end
                StPwrup: begin
                    if (cnt_q == PWRUP_LAST) begin
                        step_q  <= StepCmd0;
                        state_q <= StSend;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSend: begin
                    o_tx_en   <= 1'b1;
                    o_tx_cmd  <= cur_cmd;
                    o_tx_para <= cur_para;
                    state_q   <= StWaitTx;
                end
                StWaitTx: begin
                    if (i_tx_done) begin
                        cnt_q <= '0;
                        if (step_q == StepCmd0) begin
                            step_q  <= StepCmd8;
                            state_q <= StGap;
                        end else begin
                            o_rx_listen   <= 1'b1;
                            o_rx_rsp136en <= (step_q == StepCmd2);
                            state_q       <= StWaitRsp;
                        end
                    end
                end
                StWaitRsp: begin
                    // A response landing on the terminal count still counts as in time.
                    if (i_rx_done) begin
                        o_rx_listen   <= 1'b0;
                        o_rx_rsp136en <= 1'b0;
                        cnt_q         <= '0;
                        if (step_q == StepAcmd41) begin
                            if (i_rx_arg[31]) o_ccs <= i_rx_arg[30];
                            else retry_q <= retry_q + 1'b1;
                        end
                        if (step_q == StepCmd3 && !i_rx_crcerr) o_rca <= i_rx_arg[31:16];
                        if (rsp_fail) begin
                            o_init_err <= 1'b1;
                            o_err_code <= cur_code;
                            o_busy     <= 1'b0;
                            clk_mod    <= 1'b1;
                            state_q    <= StErr;
                        end else if (step_q == StepCmd7) begin
                            o_init_done <= 1'b1;
                            o_busy      <= 1'b0;
                            clk_mod     <= 1'b0;
                            state_q     <= StDone;
                        end else begin
                            step_q  <= rsp_next;
                            state_q <= StGap;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        o_rx_listen   <= 1'b0;
                        o_rx_rsp136en <= 1'b0;
                        o_init_err    <= 1'b1;
                        o_err_code    <= cur_code;
                        o_busy        <= 1'b0;
                        clk_mod       <= 1'b1;
                        state_q       <= StErr;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == GAP_LAST) state_q <= StSend;
                    else cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_sdio_init_ctrl.sv
// Bench for sdio_init_ctrl: a card responder plus a step-list model of the init sequence.
module tb_sdio_init_ctrl;
    localparam int PWRUP = 80;
    localparam int GAP   = 16;
    localparam int TO    = 4096;
    localparam int RETRY = 4;

    logic        ctrl_clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        o_tx_en;
    logic [5:0]  o_tx_cmd;
    logic [31:0] o_tx_para;
    logic        i_tx_done = 1'b0;
    logic        o_rx_listen;
    logic        o_rx_rsp136en;
    logic        i_rx_done = 1'b0;
    logic        i_rx_crcerr = 1'b0;
    logic [31:0] i_rx_arg = 32'h0;
    logic        clk_mod;
    logic        o_busy;
    logic        o_init_done;
    logic        o_init_err;
    logic [3:0]  o_err_code;
    logic [15:0] o_rca;
    logic        o_ccs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] echo;
        int          busy;
        logic        ccs;
        logic [15:0] rca;
        int          crc_cmd;
        int          late_cmd;
        int          late_dly;
        bit          restart;
        int          rst_cmd;
        bit          exp_done;
        logic [3:0]  exp_code;
        logic [15:0] exp_rca;
        logic        exp_ccs;
        int          exp_ncmd;
    } scen_t;

    int          exp_cmd[$];
    logic [31:0] exp_para[$];
    int          obs_cmd[$];
    logic [31:0] obs_para[$];

    sdio_init_ctrl #(
        .PWRUP_CYC   (PWRUP),
        .GAP_CYC     (GAP),
        .RSP_TIMEOUT (TO),
        .ACMD41_RETRY(RETRY)
    ) dut (
        .ctrl_clk     (ctrl_clk),
        .rst          (rst),
        .i_start      (i_start),
        .o_tx_en      (o_tx_en),
        .o_tx_cmd     (o_tx_cmd),
        .o_tx_para    (o_tx_para),
        .i_tx_done    (i_tx_done),
        .o_rx_listen  (o_rx_listen),
        .o_rx_rsp136en(o_rx_rsp136en),
        .i_rx_done    (i_rx_done),
        .i_rx_crcerr  (i_rx_crcerr),
        .i_rx_arg     (i_rx_arg),
        .clk_mod      (clk_mod),
        .o_busy       (o_busy),
        .o_init_done  (o_init_done),
        .o_init_err   (o_init_err),
        .o_err_code   (o_err_code),
        .o_rca        (o_rca),
        .o_ccs        (o_ccs)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".tx_en"}, 32'(o_tx_en), 0);
        chk({tag, ".tx_cmd"}, 32'(o_tx_cmd), 0);
        chk({tag, ".tx_para"}, o_tx_para, 0);
        chk({tag, ".listen"}, 32'(o_rx_listen), 0);
        chk({tag, ".rsp136"}, 32'(o_rx_rsp136en), 0);
        chk({tag, ".clk_mod"}, 32'(clk_mod), 1);
        chk({tag, ".busy"}, 32'(o_busy), 0);
        chk({tag, ".done"}, 32'(o_init_done), 0);
        chk({tag, ".err"}, 32'(o_init_err), 0);
        chk({tag, ".err_code"}, 32'(o_err_code), 0);
        chk({tag, ".rca"}, 32'(o_rca), 0);
        chk({tag, ".ccs"}, 32'(o_ccs), 0);
    endtask

    function automatic bit fails(input scen_t s, input int cmd);
        return (s.crc_cmd == cmd && cmd != 41) || (s.late_cmd == cmd && s.late_dly >= TO);
    endfunction

    // Walks the bring-up script for one card behaviour and lists the commands it should see.
    function automatic void model(input scen_t s, output bit done, output logic [3:0] code,
                                  output logic [15:0] rca, output logic ccs);
        bit ready;
        done = 0; code = 0; rca = 0; ccs = 0; ready = 0;
        exp_cmd.delete(); exp_para.delete();
        exp_cmd.push_back(0);  exp_para.push_back(32'h0);
        exp_cmd.push_back(8);  exp_para.push_back(32'h1AA);
        if (fails(s, 8) || s.echo != 12'h1AA) begin code = 1; return; end
        for (int a = 0; a < RETRY; a++) begin
            exp_cmd.push_back(55); exp_para.push_back({rca, 16'h0});
            if (fails(s, 55)) begin code = 6; return; end
            exp_cmd.push_back(41); exp_para.push_back(32'h40FF_8000);
            if (fails(s, 41)) begin code = 2; return; end
            if (a >= s.busy) begin ccs = s.ccs; ready = 1; break; end
        end
        if (!ready) begin code = 2; return; end
        exp_cmd.push_back(2); exp_para.push_back(32'h0);
        if (fails(s, 2)) begin code = 3; return; end
        exp_cmd.push_back(3); exp_para.push_back(32'h0);
        if (fails(s, 3)) begin code = 4; return; end
        rca = s.rca;
        if (rca == 16'h0) begin code = 4; return; end
        exp_cmd.push_back(7); exp_para.push_back({rca, 16'h0});
        if (fails(s, 7)) begin code = 5; return; end
        done = 1;
    endfunction

    function automatic scen_t mk(input logic [11:0] echo, input int busy, input logic ccs,
                                 input logic [15:0] rca, input int crc_cmd, input int late_cmd,
                                 input int late_dly, input bit restart, input int rst_cmd,
                                 input bit exp_done, input logic [3:0] exp_code,
                                 input logic [15:0] exp_rca, input logic exp_ccs,
                                 input int exp_ncmd);
        scen_t s;
        s.echo = echo; s.busy = busy; s.ccs = ccs; s.rca = rca; s.crc_cmd = crc_cmd;
        s.late_cmd = late_cmd; s.late_dly = late_dly; s.restart = restart;
        s.rst_cmd = rst_cmd; s.exp_done = exp_done; s.exp_code = exp_code;
        s.exp_rca = exp_rca; s.exp_ccs = exp_ccs; s.exp_ncmd = exp_ncmd;
        return s;
    endfunction

    task automatic run(input scen_t s, input string tag);
        int c, n41, w, d, k_err, cmd, n;
        bit fin, first, m_done;
        logic [3:0] m_code;
        logic [15:0] m_rca;
        logic m_ccs, crc;
        logic [31:0] arg;
        model(s, m_done, m_code, m_rca, m_ccs);
        obs_cmd.delete(); obs_para.delete();
        @(posedge ctrl_clk); #1; i_start = 1'b1;
        @(posedge ctrl_clk); #1; i_start = 1'b0;
        c = 0; n41 = 0; fin = 0; first = 1;
        while (!fin) begin
            w = 0;
            while (!o_tx_en && !o_init_done && !o_init_err && w < 1000) begin
                @(posedge ctrl_clk); #1; c++; w++;
                if (s.restart && c == 10) begin
                    // Start and stray strobes while powering up must all be ignored.
                    i_start = 1; i_tx_done = 1; i_rx_done = 1; i_rx_crcerr = 1;
                    @(posedge ctrl_clk); #1; c++; w++;
                    i_start = 0; i_tx_done = 0; i_rx_done = 0; i_rx_crcerr = 0;
                end
            end
            if (o_tx_en) begin
                if (first) begin
                    chk({tag, ".first_tx_lat"}, 32'(c), 32'(PWRUP + 1));
                    chk({tag, ".busy_run"}, 32'(o_busy), 1);
                    chk({tag, ".clk_mod_run"}, 32'(clk_mod), 1);
                    first = 0;
                end
                cmd = int'(o_tx_cmd);
                obs_cmd.push_back(cmd); obs_para.push_back(o_tx_para);
                repeat ($urandom_range(1, 4)) @(posedge ctrl_clk);
                #1; i_tx_done = 1'b1;
                @(posedge ctrl_clk); #1; i_tx_done = 1'b0;
                if (cmd == s.rst_cmd) begin
                    rst = 1'b1; #2;
                    check_reset({tag, ".mid_rst"});
                    rst = 1'b0;
                    fin = 1;
                end else if (cmd == 0) begin
                    chk({tag, ".cmd0_listen"}, 32'(o_rx_listen), 0);
                end else begin
                    chk({tag, ".listen_on"}, 32'(o_rx_listen), 1);
                    chk({tag, ".rsp136"}, 32'(o_rx_rsp136en), 32'(cmd == 2));
                    d = (cmd == s.late_cmd) ? s.late_dly : int'($urandom_range(0, 4));
                    crc = (cmd == s.crc_cmd);
                    case (cmd)
                        8:       arg = {20'h0, s.echo};
                        41:      arg = (n41 < s.busy) ? 32'h00FF_8000 : {1'b1, s.ccs, 30'h00FF_8000};
                        3:       arg = {s.rca, 16'h0520};
                        default: arg = $urandom;
                    endcase
                    k_err = 0;
                    for (int k = 1; k <= d; k++) begin
                        @(posedge ctrl_clk); #1;
                        if (o_init_err) begin k_err = k; break; end
                    end
                    if (d >= TO) begin
                        chk({tag, ".timeout_lat"}, 32'(k_err), 32'(TO));
                    end else if (k_err == 0) begin
                        i_rx_arg = arg; i_rx_crcerr = crc; i_rx_done = 1'b1;
                        @(posedge ctrl_clk); #1;
                        i_rx_done = 1'b0; i_rx_crcerr = 1'b0; i_rx_arg = 32'h0;
                        chk({tag, ".listen_off"}, 32'(o_rx_listen), 0);
                        if (cmd == 41) n41++;
                    end
                end
            end else if (o_init_done || o_init_err) begin
                fin = 1;
            end else begin
                chk({tag, ".progress"}, 32'(o_tx_en), 1);
                fin = 1;
            end
        end
        // Idle window with stray strobes: nothing may be sent and the result must hold.
        w = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5 || i == 20) begin
                i_tx_done = 1; i_rx_done = 1; i_rx_crcerr = 1; i_rx_arg = 32'hFFFF_FFFF;
            end
            @(posedge ctrl_clk); #1;
            i_tx_done = 0; i_rx_done = 0; i_rx_crcerr = 0; i_rx_arg = 32'h0;
            if (o_tx_en) w++;
        end
        chk({tag, ".quiet"}, 32'(w), 0);
        chk({tag, ".done"}, 32'(o_init_done), 32'(s.exp_done));
        chk({tag, ".err"}, 32'(o_init_err), 32'(!s.exp_done && s.exp_code != 0));
        chk({tag, ".err_code"}, 32'(o_err_code), 32'(s.exp_code));
        chk({tag, ".rca"}, 32'(o_rca), 32'(s.exp_rca));
        chk({tag, ".ccs"}, 32'(o_ccs), 32'(s.exp_ccs));
        chk({tag, ".clk_mod"}, 32'(clk_mod), 32'(!s.exp_done));
        chk({tag, ".busy"}, 32'(o_busy), 0);
        chk({tag, ".ncmd"}, 32'(obs_cmd.size()), 32'(s.exp_ncmd));
        n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.cmd%0d", tag, i), 32'(obs_cmd[i]), 32'(exp_cmd[i]));
            chk($sformatf("%s.para%0d", tag, i), obs_para[i], exp_para[i]);
        end
    endtask

    initial begin
        scen_t tbl[$];
        scen_t s;
        int picks[6];
        bit m_done;
        logic [3:0] m_code;
        logic [15:0] m_rca;
        logic m_ccs;
        picks = '{8, 55, 41, 2, 3, 7};
        //                  echo    busy ccs rca       crc late dly   rs rst  done code rca  ccs n
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234, -1, -1, 0,    0, -1, 1, 0, 16'h1234, 1, 7));
        tbl.push_back(mk(12'h1AA,  3, 0, 16'hBEEF, -1, -1, 0,    0, -1, 1, 0, 16'hBEEF, 0, 13));
        tbl.push_back(mk(12'h0AA,  0, 1, 16'h1234, -1, -1, 0,    0, -1, 0, 1, 16'h0,    0, 2));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234, -1,  3, TO,   0, -1, 0, 4, 16'h0,    1, 6));
        tbl.push_back(mk(12'h1AA, 99, 1, 16'h1234, -1, -1, 0,    0, -1, 0, 2, 16'h0,    0, 10));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h0000, -1, -1, 0,    0, -1, 0, 4, 16'h0,    1, 6));
        tbl.push_back(mk(12'h1AA,  1, 1, 16'h0001, 41, -1, 0,    0, -1, 1, 0, 16'h0001, 1, 9));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234, 55, -1, 0,    0, -1, 0, 6, 16'h0,    0, 3));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234,  2, -1, 0,    0, -1, 0, 3, 16'h0,    1, 5));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h00A5,  7, -1, 0,    0, -1, 0, 5, 16'h00A5, 1, 7));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h4321, -1,  7, TO-1, 0, -1, 1, 0, 16'h4321, 1, 7));
        tbl.push_back(mk(12'h1AA,  0, 0, 16'h0F0F, -1, -1, 0,    1, -1, 1, 0, 16'h0F0F, 0, 7));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234,  8, -1, 0,    0, -1, 0, 1, 16'h0,    0, 2));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234,  3, -1, 0,    0, -1, 0, 4, 16'h0,    1, 6));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234, -1, -1, 0,    0,  2, 0, 0, 16'h0,    0, 5));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h7777, -1, -1, 0,    0, -1, 1, 0, 16'h7777, 1, 7));
        tbl.push_back(mk(12'h1AA,  0, 1, 16'h1234, -1, 55, TO,   0, -1, 0, 6, 16'h0,    0, 3));

        repeat (3) @(posedge ctrl_clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i));

        for (int r = 0; r < 20; r++) begin
            s = mk(12'h1AA, 0, 1'b0, 16'h0, -1, -1, 0, 0, -1, 0, 0, 16'h0, 1'b0, 0);
            if ($urandom_range(0, 5) == 0) s.echo = 12'($urandom);
            s.busy = int'($urandom_range(0, 5));
            s.ccs = 1'($urandom);
            s.rca = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 2) == 0) s.crc_cmd = picks[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) begin
                s.late_cmd = picks[$urandom_range(0, 5)];
                s.late_dly = TO - 1;
            end
            model(s, m_done, m_code, m_rca, m_ccs);
            s.exp_done = m_done; s.exp_code = m_code; s.exp_rca = m_rca; s.exp_ccs = m_ccs;
            s.exp_ncmd = exp_cmd.size();
            run(s, $sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
